// File: rtl/util_distribute_fifo_if.sv
// Handshake bundle for util_distribute_fifo: wide write side, narrow read side.
// The producer/consumer side takes the master modport; the FIFO takes slave.
interface util_distribute_fifo_if #(
    parameter int READ_WIDTH  = 32,
    parameter int WRITE_SCALE = 2,
    parameter int DEPTH       = 8
);
    localparam int CW = $clog2(DEPTH * WRITE_SCALE + 1);

    logic                              wr_en;
    logic                              full;
    logic [READ_WIDTH*WRITE_SCALE-1:0] din;
    logic                              rd_en;
    logic                              empty;
    logic [READ_WIDTH-1:0]             dout;
    logic [CW-1:0]                     rd_count;

    modport master (
        output wr_en, din, rd_en,
        input  full, empty, dout, rd_count
    );

    modport slave (
        input  wr_en, din, rd_en,
        output full, empty, dout, rd_count
    );
endinterface

// File: rtl/util_distribute_fifo.sv
// Width-splitting FIFO: one wide word in, WRITE_SCALE narrow words out, LSB slice first.
// An entry stays occupied until its last slice is read; flags come from registered state only.
module util_distribute_fifo #(
    parameter int READ_WIDTH  = 32,
    parameter int WRITE_SCALE = 2,
    parameter int DEPTH       = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    util_distribute_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(WRITE_SCALE);
    localparam int CW = $clog2(DEPTH * WRITE_SCALE + 1);

    localparam logic [SW-1:0] SEL_LAST = SW'(WRITE_SCALE - 1);
    localparam logic [CW-1:0] CNT_WR   = CW'(WRITE_SCALE);
    localparam logic [CW-1:0] CNT_RW   = CW'(WRITE_SCALE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WRITE_SCALE-1:0][READ_WIDTH-1:0] mem [DEPTH];

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [SW-1:0]         sel;
    logic [READ_WIDTH-1:0] dout_q;
    logic [CW-1:0]         count;

    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;
    logic rd_last;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign wr_acc  = bus.wr_en && !full;
    assign rd_acc  = bus.rd_en && !empty;
    assign rd_last = rd_acc && (sel == SEL_LAST);

    // Storage is left uninitialised across reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            sel    <= '0;
            dout_q <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                dout_q <= mem[rd_ptr[AW-1:0]][sel];
                if (rd_last) begin
                    sel    <= '0;
                    rd_ptr <= rd_ptr + 1'b1;
                end else begin
                    sel <= sel + 1'b1;
                end
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_WR;
                2'b01:   count <= count - CNT_ONE;
                2'b11:   count <= count + CNT_RW;
                default: count <= count;
            endcase
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.dout     = dout_q;
    assign bus.rd_count = count;
endmodule

// File: tb/tb_util_distribute_fifo.sv
// Self-checking bench for util_distribute_fifo: directed scenarios plus random traffic
// compared against a queue model of narrow words.
module tb_util_distribute_fifo;
    localparam int RW = 32;
    localparam int WS = 2;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    util_distribute_fifo_if #(.READ_WIDTH(RW), .WRITE_SCALE(WS), .DEPTH(D)) bus ();

    util_distribute_fifo #(.READ_WIDTH(RW), .WRITE_SCALE(WS), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [RW-1:0] model_q[$];
    logic [RW-1:0] exp_dout = '0;
    int max_count = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int model_entries();
        return (model_q.size() + WS - 1) / WS;
    endfunction

    function automatic logic model_full();
        return model_entries() == D;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".full"},     64'(bus.full),     64'(model_full()));
        chk({tag, ".empty"},    64'(bus.empty),    64'(model_q.size() == 0));
        chk({tag, ".rd_count"}, 64'(bus.rd_count), 64'(model_q.size()));
        chk({tag, ".dout"},     64'(bus.dout),     64'(exp_dout));
    endtask

    // One clock: decide acceptance from pre-edge model state, clock, update model, check.
    task automatic cycle(input logic we, input logic [RW*WS-1:0] d, input logic re, input string tag);
        logic acc_w, acc_r;
        bus.wr_en = we;
        bus.din   = d;
        bus.rd_en = re;
        acc_w = we && !model_full();
        acc_r = re && (model_q.size() != 0);
        @(posedge clk);
        #1;
        if (acc_r) exp_dout = model_q.pop_front();
        if (acc_w) for (int s = 0; s < WS; s++) model_q.push_back(d[s*RW +: RW]);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check_state(tag);
        if (model_q.size() > max_count) max_count = model_q.size();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_q.delete();
        exp_dout = '0;
        check_state(tag);
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;

        // reset then idle
        do_reset("reset");
        cycle(1'b0, '0, 1'b0, "idle");
        chk("idle.dout_zero", 64'(bus.dout), 64'h0);

        // single write and drain
        cycle(1'b1, 64'hAAAA_BBBB_1111_2222, 1'b0, "single_wr");
        chk("single_wr.count2", 64'(bus.rd_count), 64'd2);
        cycle(1'b0, '0, 1'b1, "single_rd0");
        chk("single_rd0.val", 64'(bus.dout), 64'h1111_2222);
        cycle(1'b0, '0, 1'b1, "single_rd1");
        chk("single_rd1.val", 64'(bus.dout), 64'hAAAA_BBBB);
        chk("single_done.empty", 64'(bus.empty), 64'd1);

        // fill to full
        for (int i = 0; i < D; i++) cycle(1'b1, (64'(i + 1) << 32) | 64'(i), 1'b0, "fill");
        chk("fill.full", 64'(bus.full), 64'd1);
        chk("fill.count16", 64'(bus.rd_count), 64'd16);
        cycle(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, "overflow");
        chk("overflow.count16", 64'(bus.rd_count), 64'd16);

        // partial read at full, then last-slice read with a concurrent (rejected) write
        cycle(1'b0, '0, 1'b1, "part_rd0");
        chk("part_rd0.full", 64'(bus.full), 64'd1);
        chk("part_rd0.count15", 64'(bus.rd_count), 64'd15);
        chk("drain.w0", 64'(bus.dout), 64'd0);
        cycle(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, "part_rd1");
        chk("part_rd1.full", 64'(bus.full), 64'd0);
        chk("part_rd1.count14", 64'(bus.rd_count), 64'd14);
        chk("drain.w1", 64'(bus.dout), 64'd1);
        for (int k = 2; k < 2 * D; k++) begin
            cycle(1'b0, '0, 1'b1, "drain");
            chk($sformatf("drain.w%0d", k), 64'(bus.dout), 64'(k / 2 + k % 2));
        end
        chk("drain.empty", 64'(bus.empty), 64'd1);
        cycle(1'b0, '0, 1'b1, "underflow");

        // steady state: write every 2 cycles, continuous reads
        max_count = 0;
        for (int c = 0; c < 100; c++)
            cycle((c % 2) == 0, {$urandom, $urandom}, 1'b1, "steady");
        chk("steady.max_count_le2", 64'(max_count <= 2), 64'd1);

        // random traffic
        for (int c = 0; c < 300; c++)
            cycle($urandom_range(0, 99) < 55, {$urandom, $urandom}, $urandom_range(0, 99) < 50, "random");
        for (int c = 0; c < 2 * D * WS; c++) cycle(1'b0, '0, 1'b1, "rand_drain");

        // reset mid-entry
        cycle(1'b1, 64'h0000_0002_0000_0001, 1'b0, "mid_wr");
        cycle(1'b0, '0, 1'b1, "mid_rd");
        chk("mid_rd.val", 64'(bus.dout), 64'd1);
        do_reset("mid_reset");
        chk("mid_reset.empty", 64'(bus.empty), 64'd1);
        chk("mid_reset.dout", 64'(bus.dout), 64'd0);
        cycle(1'b1, 64'h0000_0004_0000_0003, 1'b0, "post_wr");
        cycle(1'b0, '0, 1'b1, "post_rd0");
        chk("post_rd0.val", 64'(bus.dout), 64'd3);
        cycle(1'b0, '0, 1'b1, "post_rd1");
        chk("post_rd1.val", 64'(bus.dout), 64'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
